// File: rtl/regfile_pkg.sv
// Shared types and helpers for the 2-read/1-write register file.
// Holds the clear FSM states, default sizes and the byte-merge function.
package regfile_pkg;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 8;

  // Returns old_w with the bytes selected by be replaced from new_w.
  // Fixed at the default width because SV functions cannot take a width
  // parameter; other widths use merge_byte in a per-byte loop.
  function automatic logic [DEF_DATA_W-1:0] merge_word(
    input logic [DEF_DATA_W-1:0]   old_w,
    input logic [DEF_DATA_W-1:0]   new_w,
    input logic [DEF_DATA_W/8-1:0] be
  );
    logic [DEF_DATA_W-1:0] w;
    for (int b = 0; b < DEF_DATA_W/8; b++) begin
      w[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return w;
  endfunction

  // One byte of the merge.
  function automatic logic [7:0] merge_byte(
    input logic [7:0] old_b,
    input logic [7:0] new_b,
    input logic       be
  );
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: range check, write-first bypass, output reg.
// The valid flag pulses for one cycle per accepted read.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] entry,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic              in_range;
  logic              hit;
  logic [DATA_W-1:0] word;

  assign in_range = {1'b0, addr} < LIMIT;
  assign hit      = wr_en && (wr_addr == addr);

  // Word to capture: stored entry, bypassed write bytes, zero if out of range.
  always_comb begin
    word = entry;
    if (hit) begin
      for (int b = 0; b < BE_W; b++) begin
        word[8*b +: 8] = merge_byte(entry[8*b +: 8],
                                    wr_data[8*b +: 8], wr_be[b]);
      end
    end
    if (!in_range) word = '0;
  end

  // Output register; data holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) data <= word;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with one byte-enabled write port, two read ports and a
// sequential clear engine that zeroes one entry per cycle.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int BE_W   = DATA_W/8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic [BE_W-1:0]   WrBe,
  input  logic              RdEn0,
  input  logic              RdEn1,
  input  logic [ADDR_W-1:0] RdAddr0,
  input  logic [ADDR_W-1:0] RdAddr1,
  output logic [DATA_W-1:0] RdData0,
  output logic [DATA_W-1:0] RdData1,
  output logic              RdValid0,
  output logic              RdValid1,
  input  logic              ClrReq,
  output logic              Busy
);

  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH-1);

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state, state_nx;
  logic [ADDR_W-1:0] cnt, cnt_nx;
  logic              idle;
  logic              wr_ok;
  logic [DATA_W-1:0] wr_word;

  assign idle  = (state == IDLE);
  assign wr_ok = idle && WrEn && ({1'b0, WrAddr} < LIMIT);
  assign Busy  = (state == CLEAR);

  // Merge the selected write bytes into the stored word.
  always_comb begin
    wr_word = mem[WrAddr];
    for (int b = 0; b < BE_W; b++) begin
      wr_word[8*b +: 8] = merge_byte(mem[WrAddr][8*b +: 8],
                                     WrData[8*b +: 8], WrBe[b]);
    end
  end

  // Clear FSM next state and counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (ClrReq) state_nx = CLEAR;
      end
      CLEAR: begin
        if (cnt == LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state and clear counter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Storage: clear engine zeroes one entry per cycle, else accept writes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (Busy) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[WrAddr] <= wr_word;
    end
  end

  regfile_rd_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BE_W(BE_W)
  ) u_rd0 (
    .clk    (CLK),
    .rst_n  (RST),
    .en     (RdEn0 && idle),
    .addr   (RdAddr0),
    .entry  (mem[RdAddr0]),
    .wr_en  (wr_ok),
    .wr_addr(WrAddr),
    .wr_data(WrData),
    .wr_be  (WrBe),
    .data   (RdData0),
    .valid  (RdValid0)
  );

  regfile_rd_port #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .BE_W(BE_W)
  ) u_rd1 (
    .clk    (CLK),
    .rst_n  (RST),
    .en     (RdEn1 && idle),
    .addr   (RdAddr1),
    .entry  (mem[RdAddr1]),
    .wr_en  (wr_ok),
    .wr_addr(WrAddr),
    .wr_data(WrData),
    .wr_be  (WrBe),
    .data   (RdData1),
    .valid  (RdValid1)
  );

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: DEPTH=8 instance plus a DEPTH=6 one.
// Expected values are hand-computed constants.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        wr_en, rd_en0, rd_en1, clr;
  logic [2:0]  wr_addr, rd_addr0, rd_addr1;
  logic [15:0] wr_data;
  logic [1:0]  wr_be;
  logic [15:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, busy;

  logic        wr_en6, rd_en06, rd_en16, clr6;
  logic [2:0]  wr_addr6, rd_addr06, rd_addr16;
  logic [15:0] wr_data6;
  logic [1:0]  wr_be6;
  logic [15:0] rd_data06, rd_data16;
  logic        rd_valid06, rd_valid16, busy6;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_W(16), .DEPTH(8)) dut (
    .CLK(clk), .RST(rst_n),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrBe(wr_be),
    .RdEn0(rd_en0), .RdEn1(rd_en1),
    .RdAddr0(rd_addr0), .RdAddr1(rd_addr1),
    .RdData0(rd_data0), .RdData1(rd_data1),
    .RdValid0(rd_valid0), .RdValid1(rd_valid1),
    .ClrReq(clr), .Busy(busy)
  );

  regfile_2r1w #(.DATA_W(16), .DEPTH(6)) dut6 (
    .CLK(clk), .RST(rst_n),
    .WrEn(wr_en6), .WrAddr(wr_addr6), .WrData(wr_data6), .WrBe(wr_be6),
    .RdEn0(rd_en06), .RdEn1(rd_en16),
    .RdAddr0(rd_addr06), .RdAddr1(rd_addr16),
    .RdData0(rd_data06), .RdData1(rd_data16),
    .RdValid0(rd_valid06), .RdValid1(rd_valid16),
    .ClrReq(clr6), .Busy(busy6)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d,
                    input logic [1:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a0, input logic [2:0] a1);
    rd_en0 = 1'b1; rd_en1 = 1'b1; rd_addr0 = a0; rd_addr1 = a1;
    tick();
    rd_en0 = 1'b0; rd_en1 = 1'b0;
  endtask

  task automatic wr6(input logic [2:0] a, input logic [15:0] d,
                     input logic [1:0] be);
    wr_en6 = 1'b1; wr_addr6 = a; wr_data6 = d; wr_be6 = be;
    tick();
    wr_en6 = 1'b0;
  endtask

  task automatic rd6(input logic [2:0] a0, input logic [2:0] a1);
    rd_en06 = 1'b1; rd_en16 = 1'b1; rd_addr06 = a0; rd_addr16 = a1;
    tick();
    rd_en06 = 1'b0; rd_en16 = 1'b0;
  endtask

  initial begin
    int n_busy;
    bit saw_valid;

    rst_n = 1'b0;
    wr_en = 0; rd_en0 = 0; rd_en1 = 0; clr = 0;
    wr_addr = 0; rd_addr0 = 0; rd_addr1 = 0; wr_data = 0; wr_be = 0;
    wr_en6 = 0; rd_en06 = 0; rd_en16 = 0; clr6 = 0;
    wr_addr6 = 0; rd_addr06 = 0; rd_addr16 = 0; wr_data6 = 0; wr_be6 = 0;

    #3;
    chk("rst_data0", rd_data0, 0);
    chk("rst_valid0", rd_valid0, 0);
    chk("rst_busy", busy, 0);
    #9 rst_n = 1'b1;
    tick();

    // All entries read zero after reset, valid pulses once per read.
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(7 - i));
      chk($sformatf("init_d0_%0d", i), rd_data0, 0);
      chk($sformatf("init_d1_%0d", i), rd_data1, 0);
      chk($sformatf("init_v0_%0d", i), rd_valid0, 1);
      chk($sformatf("init_v1_%0d", i), rd_valid1, 1);
    end
    tick();
    chk("valid0_drop", rd_valid0, 0);
    chk("valid1_drop", rd_valid1, 0);

    // Partial-word write.
    wr(3, 16'hABCD, 2'b11);
    wr(3, 16'h1234, 2'b01);
    rd(3, 3);
    chk("be_merge0", rd_data0, 16'hAB34);
    chk("be_merge1", rd_data1, 16'hAB34);
    wr(3, 16'hFFFF, 2'b00);
    rd(3, 0);
    chk("be_zero", rd_data0, 16'hAB34);

    // Write-first bypass on both ports.
    rd_en0 = 1; rd_en1 = 1; rd_addr0 = 5; rd_addr1 = 5;
    wr(5, 16'h5A5A, 2'b11);
    rd_en0 = 0; rd_en1 = 0;
    chk("byp_d0", rd_data0, 16'h5A5A);
    chk("byp_d1", rd_data1, 16'h5A5A);
    rd_en0 = 1; rd_addr0 = 3;
    wr(3, 16'h00EE, 2'b10);
    rd_en0 = 0;
    chk("byp_part", rd_data0, 16'h0034);

    // Fill, then clear while hammering reads.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hFFFF, 2'b11);
    rd(6, 6);
    clr = 1;
    tick();
    clr = 0;
    rd_en0 = 1; rd_en1 = 1; rd_addr0 = 2; rd_addr1 = 4;
    wr_en = 1; wr_addr = 1; wr_data = 16'h7777; wr_be = 2'b11;
    n_busy = 0;
    saw_valid = 0;
    while (busy && n_busy < 20) begin
      n_busy++;
      if (rd_valid0 || rd_valid1) saw_valid = 1;
      tick();
    end
    if (rd_valid0 || rd_valid1) saw_valid = 1;
    rd_en0 = 0; rd_en1 = 0; wr_en = 0;
    chk("clr_busy_cycles", n_busy, 8);
    chk("clr_no_valid", saw_valid, 0);
    chk("clr_data_hold", rd_data0, 16'hFFFF);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(i));
      chk($sformatf("clr_zero_%0d", i), rd_data0, 0);
    end

    // Async reset in the middle of a clear.
    wr(7, 16'hFFFF, 2'b11);
    wr(0, 16'hFFFF, 2'b11);
    rd(7, 0);
    chk("pre_rst_d0", rd_data0, 16'hFFFF);
    clr = 1;
    tick();
    clr = 0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("midclr_busy", busy, 0);
    chk("midclr_d0", rd_data0, 0);
    chk("midclr_d1", rd_data1, 0);
    chk("midclr_v0", rd_valid0, 0);
    #2 rst_n = 1'b1;
    wr(7, 16'h1357, 2'b11);
    rd(7, 0);
    chk("post_rst_a7", rd_data0, 16'h1357);
    chk("post_rst_a0", rd_data1, 0);

    // DEPTH=6: out-of-range writes ignored, reads return zero but valid.
    wr6(0, 16'h1111, 2'b11);
    wr6(6, 16'h2222, 2'b11);
    wr6(7, 16'h3333, 2'b11);
    rd6(6, 0);
    chk("d6_oob_data", rd_data06, 0);
    chk("d6_oob_valid", rd_valid06, 1);
    chk("d6_a0", rd_data16, 16'h1111);
    wr6(5, 16'h4444, 2'b11);
    wr6(0, 16'h9900, 2'b10);
    rd6(5, 0);
    chk("d6_last", rd_data06, 16'h4444);
    chk("d6_a0_merge", rd_data16, 16'h9911);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
